// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//
// Turns single-beat core requests (read or write) into AXI4-Lite transactions
// and reports each completion with a one-cycle RSP_VALID pulse.
//
// Ports:
//   ACLK, ARESETn                  clock and asynchronous active-low reset
//   REQ_VALID/REQ_READY            core request handshake
//   REQ_WE, REQ_ADDR,              request direction, address, write data
//   REQ_WDATA, REQ_WSTRB           and byte enables
//   RSP_VALID, RSP_RDATA, RSP_ERR  completion pulse, read data, error flag
//   AR_* / R_*                     AXI4-Lite read address and read data channels
//   AW_* / W_* / B_*               AXI4-Lite write address, data and response
//
// Optional feature:
//   AXI_MASTER_TIMEOUT_EN - enables a watchdog that abandons a transaction
//   after TIMEOUT_CYCLES cycles outside IDLE and completes it with an error.
//   Without it the master waits indefinitely and TIMEOUT_CYCLES is unused.
// -----------------------------------------------------------------------------
module axi4_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WE,
    input  logic [ADDR_W-1:0]   REQ_ADDR,
    input  logic [DATA_W-1:0]   REQ_WDATA,
    input  logic [DATA_W/8-1:0] REQ_WSTRB,
    output logic                RSP_VALID,
    output logic [DATA_W-1:0]   RSP_RDATA,
    output logic                RSP_ERR,
    output logic                AR_VALID,
    input  logic                AR_READY,
    output logic [ADDR_W-1:0]   AR_ADDR,
    input  logic                R_VALID,
    output logic                R_READY,
    input  logic [DATA_W-1:0]   R_DATA,
    input  logic [1:0]          R_RESP,
    output logic                AW_VALID,
    input  logic                AW_READY,
    output logic [ADDR_W-1:0]   AW_ADDR,
    output logic                W_VALID,
    input  logic                W_READY,
    output logic [DATA_W-1:0]   W_DATA,
    output logic [DATA_W/8-1:0] W_STRB,
    input  logic                B_VALID,
    output logic                B_READY,
    input  logic [1:0]          B_RESP
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awPend_q, awPend_d;
    logic                wPend_q, wPend_d;
    logic                rspValid_q, rspValid_d;
    logic [DATA_W-1:0]   rspRdata_q, rspRdata_d;
    logic                rspErr_q, rspErr_d;

    // Only the error bit of each response is meaningful to the core.
    logic unusedInputs;
    assign unusedInputs = R_RESP[0] ^ B_RESP[0];

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout;

    // Counts cycles spent outside IDLE; the last counted cycle fires the
    // timeout so the abort happens after exactly TIMEOUT_CYCLES busy cycles.
    assign timeout = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign timer_d = ((state_q == IDLE) || timeout) ? '0 : timer_q + TW'(1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and handshake outputs. Every VALID/READY is a function of
    // registered state only, so none depends combinationally on the slave.
    // REQ_READY stays low during the completion pulse so the core sees the
    // response before it can issue the next request.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awPend_d   = awPend_q;
        wPend_d    = wPend_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        REQ_READY  = 1'b0;
        AR_VALID   = 1'b0;
        R_READY    = 1'b0;
        AW_VALID   = 1'b0;
        W_VALID    = 1'b0;
        B_READY    = 1'b0;

        case (state_q)
            IDLE: begin
                REQ_READY = !rspValid_q;
                if (REQ_VALID && !rspValid_q) begin
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    wstrb_d = REQ_WSTRB;
                    if (REQ_WE) begin
                        awPend_d = 1'b1;
                        wPend_d  = 1'b1;
                        state_d  = WR;
                    end else begin
                        state_d  = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                AR_VALID = 1'b1;
                if (AR_READY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                R_READY = 1'b1;
                if (R_VALID) begin
                    rspValid_d = 1'b1;
                    rspRdata_d = R_DATA;
                    rspErr_d   = R_RESP[1];
                    state_d    = IDLE;
                end
            end
            WR: begin
                // Address and data channels retire independently.
                AW_VALID = awPend_q;
                W_VALID  = wPend_q;
                if (awPend_q && AW_READY) begin
                    awPend_d = 1'b0;
                end
                if (wPend_q && W_READY) begin
                    wPend_d = 1'b0;
                end
                if (!awPend_d && !wPend_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                B_READY = 1'b1;
                if (B_VALID) begin
                    rspValid_d = 1'b1;
                    rspErr_d   = B_RESP[1];
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        if (timeout) begin
            state_d    = IDLE;
            awPend_d   = 1'b0;
            wPend_d    = 1'b0;
            rspValid_d = 1'b1;
            rspErr_d   = 1'b1;
            rspRdata_d = '0;
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awPend_q   <= 1'b0;
            wPend_q    <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awPend_q   <= awPend_d;
            wPend_q    <= wPend_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    assign AR_ADDR   = addr_q;
    assign AW_ADDR   = addr_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign RSP_VALID = rspValid_q;
    assign RSP_RDATA = rspRdata_q;
    assign RSP_ERR   = rspErr_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
//
// Directed self-checking bench for axi4_lite_master. Each scenario task drives
// the core request and plays the AXI slave by hand, checking outputs #1 after
// the rising edge against hand-computed values. The watchdog scenario is only
// compiled when AXI_MASTER_TIMEOUT_EN is defined (DUT built with
// TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;

    logic        ACLK;
    logic        ARESETn;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [3:0]  REQ_WSTRB;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        AR_VALID;
    logic        AR_READY;
    logic [31:0] AR_ADDR;
    logic        R_VALID;
    logic        R_READY;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        AW_VALID;
    logic        AW_READY;
    logic [31:0] AW_ADDR;
    logic        W_VALID;
    logic        W_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        B_VALID;
    logic        B_READY;
    logic [1:0]  B_RESP;

    int checks = 0;
    int errors = 0;

    axi4_lite_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE   (REQ_WE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .REQ_WSTRB(REQ_WSTRB),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR  (RSP_ERR),
        .AR_VALID (AR_VALID),
        .AR_READY (AR_READY),
        .AR_ADDR  (AR_ADDR),
        .R_VALID  (R_VALID),
        .R_READY  (R_READY),
        .R_DATA   (R_DATA),
        .R_RESP   (R_RESP),
        .AW_VALID (AW_VALID),
        .AW_READY (AW_READY),
        .AW_ADDR  (AW_ADDR),
        .W_VALID  (W_VALID),
        .W_READY  (W_READY),
        .W_DATA   (W_DATA),
        .W_STRB   (W_STRB),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_RESP   (B_RESP)
    );

    // 100 MHz clock.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset;
        ARESETn = 1'b0;
        tick();
        tick();
        checks++;
        if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %0b want 1", REQ_READY); end
        checks++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_handshakes got %05b want 00000", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY});
        end
        checks++;
        if ({RSP_VALID, RSP_ERR} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp got %02b want 00", {RSP_VALID, RSP_ERR}); end
        checks++;
        if (RSP_RDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", RSP_RDATA); end
        checks++;
        if ({AR_ADDR, W_DATA} !== 64'h0 || W_STRB !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_addr_data got %h %h %h want 0", AR_ADDR, W_DATA, W_STRB);
        end
        ARESETn = 1'b1;
        tick();
    endtask

    // Read 0x10, always-ready slave: RSP_VALID three cycles after accept.
    task automatic test_read_basic;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h10;
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 32'hDEADBEEF; R_RESP = 2'b00;
        checks++;
        if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL rd_req_ready got %0b want 1", REQ_READY); end
        tick();
        REQ_VALID = 1'b0;
        checks++;
        if (AR_VALID !== 1'b1 || AR_ADDR !== 32'h10) begin
            errors++; $display("[TB] FAIL rd_ar got valid=%0b addr=%h want 1 00000010", AR_VALID, AR_ADDR);
        end
        checks++;
        if (REQ_READY !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_busy got ready=%0b rsp=%0b want 0 0", REQ_READY, RSP_VALID);
        end
        tick();
        checks++;
        if (R_READY !== 1'b1 || AR_VALID !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_data_phase got rready=%0b arvalid=%0b rsp=%0b want 1 0 0", R_READY, AR_VALID, RSP_VALID);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hDEADBEEF || RSP_ERR !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_rsp got v=%0b d=%h e=%0b want 1 deadbeef 0", RSP_VALID, RSP_RDATA, RSP_ERR);
        end
        checks++;
        if (R_READY !== 1'b0 || REQ_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_rsp_cycle got rready=%0b reqready=%0b want 0 0", R_READY, REQ_READY);
        end
        AR_READY = 1'b0; R_VALID = 1'b0;
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            errors++; $display("[TB] FAIL rd_pulse_end got rsp=%0b ready=%0b want 0 1", RSP_VALID, REQ_READY);
        end
    endtask

    // Write 0x20 with W_READY immediate and AW_READY after three cycles.
    task automatic test_write_delayed;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h20;
        REQ_WDATA = 32'h12345678; REQ_WSTRB = 4'hF;
        AW_READY = 1'b0; W_READY = 1'b1; B_VALID = 1'b0; B_RESP = 2'b00;
        tick();
        REQ_VALID = 1'b0; REQ_WE = 1'b0;
        checks++;
        if (AW_VALID !== 1'b1 || W_VALID !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_c1_valids got aw=%0b w=%0b want 1 1", AW_VALID, W_VALID);
        end
        checks++;
        if (AW_ADDR !== 32'h20 || W_DATA !== 32'h12345678 || W_STRB !== 4'hF) begin
            errors++; $display("[TB] FAIL wr_payload got %h %h %h want 00000020 12345678 f", AW_ADDR, W_DATA, W_STRB);
        end
        tick();
        checks++;
        if (AW_VALID !== 1'b1 || W_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_c2_valids got aw=%0b w=%0b want 1 0", AW_VALID, W_VALID);
        end
        tick();
        checks++;
        if (AW_VALID !== 1'b1 || W_VALID !== 1'b0 || AW_ADDR !== 32'h20) begin
            errors++; $display("[TB] FAIL wr_c3_valids got aw=%0b w=%0b addr=%h want 1 0 00000020", AW_VALID, W_VALID, AW_ADDR);
        end
        AW_READY = 1'b1;
        tick();
        AW_READY = 1'b0;
        checks++;
        if (AW_VALID !== 1'b0 || B_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_resp_phase got aw=%0b bready=%0b rsp=%0b want 0 1 0", AW_VALID, B_READY, RSP_VALID);
        end
        B_VALID = 1'b1;
        tick();
        B_VALID = 1'b0;
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL wr_rsp got v=%0b e=%0b d=%h want 1 0 deadbeef", RSP_VALID, RSP_ERR, RSP_RDATA);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || B_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_pulse_end got rsp=%0b bready=%0b want 0 0", RSP_VALID, B_READY);
        end
        W_READY = 1'b0;
    endtask

    // Error read immediately followed by a clean read; the core holds
    // REQ_VALID high so the second request goes in as early as allowed.
    task automatic test_back_to_back;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h30;
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 32'hCAFEF00D; R_RESP = 2'b10;
        tick();
        REQ_ADDR = 32'h34;
        tick();
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 32'hCAFEF00D) begin
            errors++; $display("[TB] FAIL b2b_err_rsp got v=%0b e=%0b d=%h want 1 1 cafef00d", RSP_VALID, RSP_ERR, RSP_RDATA);
        end
        checks++;
        if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_in_rsp got %0b want 0", REQ_READY); end
        R_DATA = 32'h0BADF00D; R_RESP = 2'b00;
        tick();
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_ready_after got ready=%0b rsp=%0b want 1 0", REQ_READY, RSP_VALID);
        end
        tick();
        REQ_VALID = 1'b0;
        checks++;
        if (AR_VALID !== 1'b1 || AR_ADDR !== 32'h34) begin
            errors++; $display("[TB] FAIL b2b_second_ar got valid=%0b addr=%h want 1 00000034", AR_VALID, AR_ADDR);
        end
        tick();
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'h0BADF00D) begin
            errors++; $display("[TB] FAIL b2b_ok_rsp got v=%0b e=%0b d=%h want 1 0 0badf00d", RSP_VALID, RSP_ERR, RSP_RDATA);
        end
        AR_READY = 1'b0; R_VALID = 1'b0;
        tick();
    endtask

    // Write with both channels ready at once and a SLVERR response.
    task automatic test_write_error;
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 32'h44;
        REQ_WDATA = 32'hA5A5_5A5A; REQ_WSTRB = 4'h3;
        AW_READY = 1'b1; W_READY = 1'b1; B_VALID = 1'b1; B_RESP = 2'b10;
        tick();
        REQ_VALID = 1'b0; REQ_WE = 1'b0;
        checks++;
        if (AW_VALID !== 1'b1 || W_VALID !== 1'b1 || W_STRB !== 4'h3) begin
            errors++; $display("[TB] FAIL wre_valids got aw=%0b w=%0b strb=%h want 1 1 3", AW_VALID, W_VALID, W_STRB);
        end
        tick();
        checks++;
        if (AW_VALID !== 1'b0 || W_VALID !== 1'b0 || B_READY !== 1'b1) begin
            errors++; $display("[TB] FAIL wre_resp_phase got aw=%0b w=%0b bready=%0b want 0 0 1", AW_VALID, W_VALID, B_READY);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 32'h0BADF00D) begin
            errors++; $display("[TB] FAIL wre_rsp got v=%0b e=%0b d=%h want 1 1 0badf00d", RSP_VALID, RSP_ERR, RSP_RDATA);
        end
        AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b00;
        tick();
    endtask

    // Reset pulled while waiting for read data.
    task automatic test_reset_mid;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h50;
        AR_READY = 1'b1; R_VALID = 1'b0;
        tick();
        REQ_VALID = 1'b0;
        tick();
        AR_READY = 1'b0;
        checks++;
        if (R_READY !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre got rready=%0b want 1", R_READY); end
        ARESETn = 1'b0;
        #1;
        checks++;
        if (R_READY !== 1'b0 || AR_VALID !== 1'b0 || REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_now got rready=%0b ar=%0b reqready=%0b rsp=%0b want 0 0 1 0",
                               R_READY, AR_VALID, REQ_READY, RSP_VALID);
        end
        R_VALID = 1'b1; R_DATA = 32'h11112222;
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0) begin
            errors++; $display("[TB] FAIL rst_mid_hold got rsp=%0b d=%h want 0 0", RSP_VALID, RSP_RDATA);
        end
        ARESETn = 1'b1;
        R_VALID = 1'b0;
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1 || R_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_after got rsp=%0b ready=%0b rready=%0b want 0 1 0", RSP_VALID, REQ_READY, R_READY);
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    // Slave never accepts the read address; watchdog fires after 8 busy cycles.
    task automatic test_timeout;
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h60;
        AR_READY = 1'b0; R_VALID = 1'b0;
        tick();
        REQ_VALID = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        checks++;
        if (AR_VALID !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL to_last_busy got ar=%0b rsp=%0b want 1 0", AR_VALID, RSP_VALID);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 32'h0 || AR_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL to_rsp got v=%0b e=%0b d=%h ar=%0b want 1 1 0 0", RSP_VALID, RSP_ERR, RSP_RDATA, AR_VALID);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin
            errors++; $display("[TB] FAIL to_after got rsp=%0b ready=%0b want 0 1", RSP_VALID, REQ_READY);
        end
    endtask
`endif

    initial begin
        ARESETn = 1'b0;
        REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
        AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = '0; R_RESP = '0;
        AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = '0;

        test_reset();
        test_read_basic();
        test_write_delayed();
        test_back_to_back();
        test_write_error();
        test_reset_mid();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 The block SHALL have one clock, ACLK, and an asynchronous active-low reset, ARESETn.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; the strobe width is DATA_W/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 256, SHALL set the watchdog limit (see REQ-025).
REQ-005 Ports SHALL be, in order:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- REQ_VALID  in  1  core request valid
- REQ_READY  out  1  request accepted
- REQ_WE  in  1  1=write, 0=read
- REQ_ADDR  in  ADDR_W  byte address
- REQ_WDATA  in  DATA_W  write data
- REQ_WSTRB  in  DATA_W/8  byte enables
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  DATA_W  read data
- RSP_ERR  out  1  error completion
- AR_VALID  out  1  read address valid
- AR_READY  in  1  read address ready
- AR_ADDR  out  ADDR_W  read address
- R_VALID  in  1  read data valid
- R_READY  out  1  read data ready
- R_DATA  in  DATA_W  read data
- R_RESP  in  2  read response
- AW_VALID  out  1  write address valid
- AW_READY  in  1  write address ready
- AW_ADDR  out  ADDR_W  write address
- W_VALID  out  1  write data valid
- W_READY  in  1  write data ready
- W_DATA  out  DATA_W  write data
- W_STRB  out  DATA_W/8  write strobes
- B_VALID  in  1  write response valid
- B_READY  out  1  write response ready
- B_RESP  in  2  write response

Function
REQ-006 The FSM SHALL use states IDLE, RD_ADDR, RD_DATA, WR, WR_RESP; REQ_READY=1 only in IDLE.
REQ-007 On REQ_VALID&&REQ_READY, the block SHALL register address, data and strobe, then go to RD_ADDR (REQ_WE=0) or WR (REQ_WE=1).
REQ-008 RD_ADDR: AR_VALID=1 with the registered address held stable until AR_READY; on handshake the FSM SHALL go to RD_DATA.
REQ-009 RD_DATA: R_READY=1; on R_VALID, RSP_RDATA<=R_DATA, RSP_ERR<=R_RESP[1], RSP_VALID pulses for one cycle, and the FSM returns to IDLE.
REQ-010 WR: AW_VALID and W_VALID SHALL assert in the same cycle, each drop independently after its own handshake, and the FSM goes to WR_RESP once both handshakes are done (same or different cycles).
REQ-011 WR_RESP: B_READY=1; on B_VALID, RSP_ERR<=B_RESP[1] and RSP_VALID pulses for one cycle; RSP_RDATA is held; the FSM returns to IDLE.
REQ-012 A VALID signal SHALL never be withdrawn before its handshake, and SHALL never depend combinationally on READY.
REQ-013 The minimum latency from request accept to RSP_VALID SHALL be 3 cycles with an always-ready slave; a new request may be accepted in the cycle after RSP_VALID.

Reset
REQ-014 While ARESETn=0, the block SHALL force state=IDLE and all outputs to 0 except REQ_READY=1; a mid-transaction reset drops all VALIDs and produces no RSP_VALID.

Configuration
REQ-025 With AXI_MASTER_TIMEOUT_EN defined, a counter SHALL run in every non-IDLE state; on reaching TIMEOUT_CYCLES, all VALID/READY outputs drop, RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0, and the FSM goes to IDLE. Without the macro, no counter exists, the block waits indefinitely, and TIMEOUT_CYCLES is unused.

Verification
REQ-030 Read 0x10 with slave ready and R_DATA=0xDEADBEEF, R_RESP=0 -> RSP_VALID 3 cycles after accept, RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
REQ-031 Write 0x20, data 0x12345678, strobe 0xF; AW_READY delayed 3 cycles, W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held 3 cycles, one RSP_VALID after B.
REQ-032 Read with R_RESP=2'b10 -> RSP_ERR=1; the following read with R_RESP=0 -> RSP_ERR=0.
REQ-033 Reset asserted in RD_DATA -> AR_VALID/R_READY=0 immediately, no RSP_VALID, REQ_READY=1; with AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never answers -> RSP_VALID with RSP_ERR=1 after 8 cycles.
